// File: rtl/fft_irq_pkg.sv
// Shared types and helpers for the FFT interrupt controller.
`timescale 1ns/1ps
package fft_irq_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE     = 2'd0,
    IRQ_COALESCE = 2'd1,
    IRQ_ACTIVE   = 2'd2
  } irq_state_t;

  localparam int SRC_DONE     = 0;
  localparam int SRC_ERROR    = 1;
  localparam int SRC_OVERFLOW = 2;
  localparam int SRC_RESCALE  = 3;
  localparam int SRC_BUF_SWAP = 4;
  localparam int SRC_EXT0     = 5;
  localparam int SRC_EXT1     = 6;
  localparam int SRC_EXT2     = 7;

  localparam int COAL_CNT_W = 8;
  localparam int TIMER_W    = 16;

  // Callers zero-extend their source vector; supports up to 32 sources.
  function automatic logic [COAL_CNT_W-1:0] popcount(input logic [31:0] v);
    logic [COAL_CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + COAL_CNT_W'(v[i]);
    end
    return n;
  endfunction

  function automatic logic [COAL_CNT_W-1:0] sat_add(input logic [COAL_CNT_W-1:0] a,
                                                    input logic [COAL_CNT_W-1:0] b);
    logic [COAL_CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[COAL_CNT_W] ? {COAL_CNT_W{1'b1}} : sum[COAL_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/fft_irq_ctrl_sync.sv
// Two-flop synchronizer for a bus of independent level signals.
`timescale 1ns/1ps
module fft_irq_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

endmodule

// File: rtl/fft_irq_ctrl.sv
// FFT interrupt controller: sticky W1C status, enable masking, count/timeout coalescing into irq_o.
// Define FFT_IRQ_SYNC_EN to synchronize evt_i from a foreign clock (adds 2 cycles of latency).
`timescale 1ns/1ps
module fft_irq_ctrl
  import fft_irq_pkg::*;
#(
  parameter int                 NUM_SRC      = 8,
  parameter logic [NUM_SRC-1:0] EDGE_MASK    = {NUM_SRC{1'b1}},
  parameter int                 COAL_THRESH  = 1,
  parameter int                 COAL_TIMEOUT = 0
) (
  input  logic               pclk_i,
  input  logic               preset_n_i,
  input  logic [NUM_SRC-1:0] evt_i,
  input  logic [NUM_SRC-1:0] int_enable_i,
  input  logic               clr_valid_i,
  input  logic [NUM_SRC-1:0] clr_mask_i,
  output logic [NUM_SRC-1:0] int_status_o,
  output logic               irq_o,
  output logic [7:0]         coal_cnt_o,
  output logic [1:0]         irq_state_o
);

  localparam logic [COAL_CNT_W-1:0] THRESH     = COAL_CNT_W'(COAL_THRESH);
  localparam logic [TIMER_W-1:0]    TIMEOUT    = TIMER_W'(COAL_TIMEOUT);
  localparam bit                    TIMEOUT_EN = (COAL_TIMEOUT != 0);

  logic [NUM_SRC-1:0] evt_cur;
  logic [NUM_SRC-1:0] evt_prev;
  logic [NUM_SRC-1:0] set;
  logic [NUM_SRC-1:0] clr_bits;
  logic [NUM_SRC-1:0] status;
  logic [NUM_SRC-1:0] status_next;

  logic                  pend_q;
  logic [COAL_CNT_W-1:0] nset_q;

  irq_state_t            state, state_next;
  logic [COAL_CNT_W-1:0] coal_cnt, cnt_next;
  logic [TIMER_W-1:0]    timer, timer_next;
  logic                  irq_q;

`ifdef FFT_IRQ_SYNC_EN
  fft_irq_sync #(
    .WIDTH (NUM_SRC)
  ) u_sync (
    .clk   (pclk_i),
    .rst_n (preset_n_i),
    .d     (evt_i),
    .q     (evt_cur)
  );

  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) evt_prev <= '0;
    else             evt_prev <= evt_cur;
  end
`else
  assign evt_cur = evt_i;

  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) evt_prev <= '0;
    else             evt_prev <= evt_i;
  end
`endif

  // Edge sources fire once per rising edge; level sources re-set every cycle they are high.
  assign set = (evt_cur & ~evt_prev & EDGE_MASK) | (evt_cur & ~EDGE_MASK);

  // Set is OR-ed after the clear so a coincident event is never lost.
  assign clr_bits    = clr_valid_i ? clr_mask_i : '0;
  assign status_next = (status & ~clr_bits) | set;

  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) begin
      status <= '0;
      pend_q <= 1'b0;
      nset_q <= '0;
    end else begin
      status <= status_next;
      pend_q <= |(status_next & int_enable_i);
      nset_q <= popcount(32'(set & int_enable_i));
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = coal_cnt;
    timer_next = timer;
    case (state)
      IRQ_IDLE: begin
        if (pend_q) begin
          cnt_next   = nset_q;
          timer_next = '0;
          state_next = (cnt_next >= THRESH) ? IRQ_ACTIVE : IRQ_COALESCE;
        end
      end
      IRQ_COALESCE: begin
        if (!pend_q) begin
          state_next = IRQ_IDLE;
          cnt_next   = '0;
          timer_next = '0;
        end else begin
          cnt_next   = sat_add(coal_cnt, nset_q);
          timer_next = (timer == {TIMER_W{1'b1}}) ? timer : timer + TIMER_W'(1);
          if ((cnt_next >= THRESH) || (TIMEOUT_EN && (timer_next == TIMEOUT))) begin
            state_next = IRQ_ACTIVE;
          end
        end
      end
      IRQ_ACTIVE: begin
        if (!pend_q) begin
          state_next = IRQ_IDLE;
          cnt_next   = '0;
          timer_next = '0;
        end else begin
          cnt_next = sat_add(coal_cnt, nset_q);
        end
      end
      default: begin
        state_next = IRQ_IDLE;
        cnt_next   = '0;
        timer_next = '0;
      end
    endcase
  end

  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) begin
      state    <= IRQ_IDLE;
      coal_cnt <= '0;
      timer    <= '0;
      irq_q    <= 1'b0;
    end else begin
      state    <= state_next;
      coal_cnt <= cnt_next;
      timer    <= timer_next;
      irq_q    <= (state_next == IRQ_ACTIVE);
    end
  end

  assign int_status_o = status;
  assign irq_o        = irq_q;
  assign coal_cnt_o   = coal_cnt;
  assign irq_state_o  = state;

endmodule

// File: tb/tb_fft_irq_ctrl.sv
// Directed bench for fft_irq_ctrl: four parameterizations share one stimulus bus.
`timescale 1ns/1ps
module tb_fft_irq_ctrl;

`ifdef FFT_IRQ_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       pclk = 1'b0;
  logic       preset_n;
  logic [7:0] evt, en, clr_mask;
  logic       clr_vld;

  logic [7:0] st  [4];
  logic       irq [4];
  logic [7:0] cnt [4];
  logic [1:0] fsm [4];

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  // A: thresh 1, timeout 4   B: thresh 3   C: level src 0   D: thresh 2
  fft_irq_ctrl #(.NUM_SRC(8), .EDGE_MASK(8'hFF), .COAL_THRESH(1), .COAL_TIMEOUT(4)) u_a (
    .pclk_i(pclk), .preset_n_i(preset_n), .evt_i(evt), .int_enable_i(en),
    .clr_valid_i(clr_vld), .clr_mask_i(clr_mask), .int_status_o(st[0]), .irq_o(irq[0]),
    .coal_cnt_o(cnt[0]), .irq_state_o(fsm[0]));
  fft_irq_ctrl #(.NUM_SRC(8), .EDGE_MASK(8'hFF), .COAL_THRESH(3), .COAL_TIMEOUT(0)) u_b (
    .pclk_i(pclk), .preset_n_i(preset_n), .evt_i(evt), .int_enable_i(en),
    .clr_valid_i(clr_vld), .clr_mask_i(clr_mask), .int_status_o(st[1]), .irq_o(irq[1]),
    .coal_cnt_o(cnt[1]), .irq_state_o(fsm[1]));
  fft_irq_ctrl #(.NUM_SRC(8), .EDGE_MASK(8'hFE), .COAL_THRESH(1), .COAL_TIMEOUT(0)) u_c (
    .pclk_i(pclk), .preset_n_i(preset_n), .evt_i(evt), .int_enable_i(en),
    .clr_valid_i(clr_vld), .clr_mask_i(clr_mask), .int_status_o(st[2]), .irq_o(irq[2]),
    .coal_cnt_o(cnt[2]), .irq_state_o(fsm[2]));
  fft_irq_ctrl #(.NUM_SRC(8), .EDGE_MASK(8'hFF), .COAL_THRESH(2), .COAL_TIMEOUT(0)) u_d (
    .pclk_i(pclk), .preset_n_i(preset_n), .evt_i(evt), .int_enable_i(en),
    .clr_valid_i(clr_vld), .clr_mask_i(clr_mask), .int_status_o(st[3]), .irq_o(irq[3]),
    .coal_cnt_o(cnt[3]), .irq_state_o(fsm[3]));

  typedef struct {
    logic [7:0] evt;
    logic [7:0] en;
    logic [7:0] clr;
    logic [7:0] st;
    logic       irq;
    logic [1:0] fsm;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge pclk);
  endtask

  task automatic do_reset();
    preset_n = 1'b0;
    evt      = '0;
    en       = '0;
    clr_vld  = 1'b0;
    clr_mask = '0;
    repeat (2) step();
    preset_n = 1'b1;
    step();
  endtask

  task automatic pulse_clr(input logic [7:0] m);
    clr_vld  = 1'b1;
    clr_mask = m;
    step();
    clr_vld  = 1'b0;
    clr_mask = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // evt, en, clr -> status, irq, state, cnt (observed on u_d after settling)
    vecs[0]  = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 2'd0, 8'd0};
    vecs[1]  = '{8'h01, 8'h00, 8'h00, 8'h01, 1'b0, 2'd0, 8'd0};
    vecs[2]  = '{8'h02, 8'h02, 8'h00, 8'h03, 1'b0, 2'd1, 8'd1};
    vecs[3]  = '{8'h04, 8'h06, 8'h00, 8'h07, 1'b1, 2'd2, 8'd2};
    vecs[4]  = '{8'h08, 8'h06, 8'h00, 8'h0F, 1'b1, 2'd2, 8'd2};
    vecs[5]  = '{8'h00, 8'h06, 8'h02, 8'h0D, 1'b1, 2'd2, 8'd2};
    vecs[6]  = '{8'h00, 8'h06, 8'h04, 8'h09, 1'b0, 2'd0, 8'd0};
    vecs[7]  = '{8'h00, 8'h09, 8'h00, 8'h09, 1'b0, 2'd1, 8'd0};
    vecs[8]  = '{8'h30, 8'hFF, 8'h00, 8'h39, 1'b1, 2'd2, 8'd2};
    vecs[9]  = '{8'h00, 8'hFF, 8'hFF, 8'h00, 1'b0, 2'd0, 8'd0};
    vecs[10] = '{8'hC0, 8'hC0, 8'h00, 8'hC0, 1'b1, 2'd2, 8'd2};
    vecs[11] = '{8'h00, 8'h00, 8'h00, 8'hC0, 1'b0, 2'd0, 8'd0};

    preset_n = 1'b0;
    evt = '0; en = '0; clr_vld = 1'b0; clr_mask = '0;
    step();
    chk("reset_status", 32'(st[0]), 32'h00);
    chk("reset_irq",    32'(irq[0]), 32'h0);
    chk("reset_cnt",    32'(cnt[0]), 32'h0);
    chk("reset_state",  32'(fsm[0]), 32'h0);

    // Basic capture and W1C on A
    do_reset();
    en = 8'h01; evt = 8'h01;
    step(); evt = '0;
    repeat (LAT) step();
    chk("basic_status", 32'(st[0]), 32'h01);
    chk("basic_irq_early", 32'(irq[0]), 32'h0);
    step();
    chk("basic_irq", 32'(irq[0]), 32'h1);
    chk("basic_state", 32'(fsm[0]), 32'h2);
    chk("basic_cnt", 32'(cnt[0]), 32'h1);
    pulse_clr(8'h01);
    chk("basic_w1c_status", 32'(st[0]), 32'h00);
    step();
    chk("basic_w1c_irq", 32'(irq[0]), 32'h0);
    chk("basic_w1c_state", 32'(fsm[0]), 32'h0);

    // Disabled source, late enable, timeout on A
    do_reset();
    evt = 8'h02;
    step(); evt = '0;
    repeat (LAT + 1) step();
    chk("dis_status", 32'(st[0]), 32'h02);
    chk("dis_irq", 32'(irq[0]), 32'h0);
    en = 8'h02;
    step();
    chk("dis_state_idle", 32'(fsm[0]), 32'h0);
    step();
    chk("dis_state_coal", 32'(fsm[0]), 32'h1);
    chk("dis_cnt_zero", 32'(cnt[0]), 32'h0);
    repeat (3) step();
    chk("dis_irq_pre_timeout", 32'(irq[0]), 32'h0);
    step();
    chk("dis_irq_timeout", 32'(irq[0]), 32'h1);

    // Set and clear of the same bit in the same cycle on A
    do_reset();
    evt = 8'h04;
    for (int i = 0; i < LAT; i++) begin
      step();
      evt = '0;
    end
    clr_vld = 1'b1; clr_mask = 8'h04;
    step();
    evt = '0; clr_vld = 1'b0; clr_mask = '0;
    chk("setclr_status", 32'(st[0]), 32'h04);
    pulse_clr(8'h04);
    chk("setclr_later_clear", 32'(st[0]), 32'h00);

    // Coalescing by count on B
    do_reset();
    en = 8'hFF;
    begin
      logic [7:0] ev_seq [3];
      ev_seq[0] = 8'h01; ev_seq[1] = 8'h04; ev_seq[2] = 8'h20;
      for (int i = 0; i < 3; i++) begin
        evt = ev_seq[i];
        step(); evt = '0;
        repeat (LAT + 1) step();
        chk($sformatf("coal_cnt_%0d", i), 32'(cnt[1]), 32'(i + 1));
        chk($sformatf("coal_irq_%0d", i), 32'(irq[1]), (i == 2) ? 32'h1 : 32'h0);
      end
    end

    // Level source on C
    do_reset();
    en = 8'h01; evt = 8'h01;
    repeat (LAT + 2) step();
    chk("level_irq", 32'(irq[2]), 32'h1);
    pulse_clr(8'h01);
    chk("level_reset_status", 32'(st[2]), 32'h01);
    step();
    chk("level_irq_held", 32'(irq[2]), 32'h1);
    repeat (300) step();
    chk("level_cnt_sat", 32'(cnt[2]), 32'd255);
    evt = '0;
    repeat (LAT + 1) step();
    pulse_clr(8'h01);
    chk("level_clear_status", 32'(st[2]), 32'h00);
    step();
    chk("level_irq_fall", 32'(irq[2]), 32'h0);
    chk("level_state_idle", 32'(fsm[2]), 32'h0);
    chk("level_cnt_clear", 32'(cnt[2]), 32'h0);

    // Table of settled vectors on D
    do_reset();
    for (int i = 0; i < 12; i++) begin
      evt = vecs[i].evt;
      en  = vecs[i].en;
      clr_vld  = (vecs[i].clr != 8'h00);
      clr_mask = vecs[i].clr;
      step();
      evt = '0; clr_vld = 1'b0; clr_mask = '0;
      repeat (3 + LAT) step();
      chk($sformatf("vec%0d_status", i), 32'(st[3]), 32'(vecs[i].st));
      chk($sformatf("vec%0d_irq", i), 32'(irq[3]), 32'(vecs[i].irq));
      chk($sformatf("vec%0d_state", i), 32'(fsm[3]), 32'(vecs[i].fsm));
      chk($sformatf("vec%0d_cnt", i), 32'(cnt[3]), 32'(vecs[i].cnt));
    end

    // Asynchronous reset while ACTIVE on A
    do_reset();
    en = 8'hFF; evt = 8'hFF;
    step(); evt = '0;
    repeat (LAT + 1) step();
    chk("arst_pre_irq", 32'(irq[0]), 32'h1);
    chk("arst_pre_status", 32'(st[0]), 32'hFF);
    #2 preset_n = 1'b0;
    #1;
    chk("arst_irq", 32'(irq[0]), 32'h0);
    chk("arst_status", 32'(st[0]), 32'h00);
    chk("arst_state", 32'(fsm[0]), 32'h0);
    chk("arst_cnt", 32'(cnt[0]), 32'h0);
    evt = 8'hFF;
    step(); evt = '0;
    step();
    preset_n = 1'b1;
    repeat (3 + LAT) step();
    chk("arst_discard_status", 32'(st[0]), 32'h00);
    chk("arst_discard_irq", 32'(irq[0]), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_irq_ctrl.md
Name: fft_irq_ctrl

Overview:
APB-clock-domain interrupt controller for the FFT accelerator.
- Captures engine events (done, error, overflow, rescale, buffer swap, external) into sticky status bits.
- Status clears by write-1-to-clear requests from the register block; status drives the register block's int_status input.
- Masks status with int_enable and coalesces pending events by count threshold or timeout before asserting a single level interrupt irq_o.

Parameters:
- NUM_SRC, 8, number of event sources (status/enable width).
- EDGE_MASK, 8'hFF, per-source capture type: 1 = rising-edge capture, 0 = level capture (set every cycle the input is high).
- COAL_THRESH, 1, number of enabled set-events needed to assert irq_o; range 1..255.
- COAL_TIMEOUT, 0, pclk cycles in COALESCE before forced assertion; 0 disables the timeout; max 65535.

Ports:
- pclk_i  in  1  APB clock.
- preset_n_i  in  1  reset, asynchronous, active-low.
- evt_i  in  NUM_SRC  raw event levels: [0] done, [1] error, [2] overflow, [3] rescaling, [4] buffer_active, [7:5] external.
- int_enable_i  in  NUM_SRC  per-source enable from the register block.
- clr_valid_i  in  1  single-cycle W1C strobe.
- clr_mask_i  in  NUM_SRC  bits to clear when clr_valid_i is high.
- int_status_o  out  NUM_SRC  sticky raw status, independent of enable.
- irq_o  out  1  level interrupt, registered.
- coal_cnt_o  out  8  enabled set-events counted since leaving IDLE, saturating.
- irq_state_o  out  2  FSM state: 0 IDLE, 1 COALESCE, 2 ACTIVE.

Behaviour:
- Reset: int_status_o=0, irq_o=0, coal_cnt_o=0, irq_state_o=IDLE, timer=0, all capture and sync flops=0.
- Capture, macro absent:
  - evt_q <= evt_i.
  - set[i] = EDGE_MASK[i] ? evt_i[i]&~evt_q[i] : evt_i[i].
  - Status bit is visible 1 cycle after evt_i is first sampled high.
- Status update: status_next = (status & ~(clr_valid_i ? clr_mask_i : 0)) | set.
  - Set and clear of the same bit in the same cycle: set wins, so no event is lost.
- Pending: pend_next = status_next & int_enable_i. nset = popcount(set & int_enable_i).
- FSM, all transitions registered:
  - IDLE:
    - If pend_next==0: stay.
    - Else coal_cnt=sat(nset) and timer=0.
    - Go to ACTIVE if coal_cnt>=COAL_THRESH, otherwise to COALESCE.
    - A level-enabled source that is already set but has no new set event gives nset=0; it enters COALESCE and asserts on timeout.
  - COALESCE:
    - Each cycle coal_cnt+=nset (saturating at 255) and timer+=1.
    - If pend_next==0 → IDLE and clear coal_cnt.
    - Else if coal_cnt_next>=COAL_THRESH, or (COAL_TIMEOUT!=0 and timer_next==COAL_TIMEOUT) → ACTIVE.
  - ACTIVE:
    - irq_o=1; coal_cnt keeps saturating-accumulating.
    - If pend_next==0 → IDLE with irq_o=0 next cycle, coal_cnt=0, timer=0.
- irq_o is 1 exactly when the state is ACTIVE; it is driven from a flop.
- Latency with COAL_THRESH=1: irq_o rises 2 cycles after evt_i is first sampled high (macro absent).
- Clearing int_enable_i bits reduces pending immediately and can return the FSM to IDLE; status is retained.
- Re-enabling a still-set bit re-enters from IDLE with nset=0.
- Timer saturates and does not wrap.
- Reset mid-operation: everything returns to reset values; events during reset are discarded.

Optional Feature:
- Macro FFT_IRQ_SYNC_EN.
- Defined: evt_i passes through a 2-flop synchronizer (s1, s2) plus an edge register s3.
  - set[i] = EDGE_MASK[i] ? s2&~s3 : s2.
  - Status latency is 3 cycles; irq latency with COAL_THRESH=1 is 4 cycles.
  - Used when evt_i comes from clk_i.
- Undefined: no synchronizer; evt_i must already be in the pclk_i domain; latencies as above.

Decomposition:
- Package fft_irq_pkg holds:
  - irq_state_t enum (IRQ_IDLE=2'd0, IRQ_COALESCE=2'd1, IRQ_ACTIVE=2'd2);
  - source index localparams (SRC_DONE=0 … SRC_EXT2=7);
  - COAL_CNT_W=8, TIMER_W=16;
  - a popcount function.
- One natural sub-module: fft_irq_sync, a parameterized-width 2-flop synchronizer, instantiated only under FFT_IRQ_SYNC_EN.

Test Plan:
- Basic capture: enable=8'h01, pulse evt_i[0] for 1 cycle → int_status_o=8'h01 next cycle, irq_o=1 one cycle later; W1C mask 8'h01 → irq_o=0 and state IDLE next cycle.
- Disabled source: enable=8'h00, pulse evt_i[1] → int_status_o=8'h02, irq_o stays 0; then enable=8'h02 → COALESCE; with COAL_TIMEOUT=4, irq_o=1 after 4 cycles.
- Coalescing: COAL_THRESH=3, COAL_TIMEOUT=0, enable=8'hFF; pulse evt_i[0], evt_i[2], evt_i[5] on separate cycles → coal_cnt 1,2,3 and irq_o asserted only after the third event.
- Simultaneous set/clear: evt_i[2] edge in the same cycle as clr_valid_i with clr_mask=8'h04 → bit 2 remains 1.
- Level source: EDGE_MASK=8'hFE, hold evt_i[0] high, then W1C bit 0 → bit re-sets the next cycle and irq_o stays 1; deassert evt_i[0] and W1C → irq_o falls.
- Async reset in ACTIVE with status=8'hFF: assert preset_n_i low mid-cycle → irq_o=0 and int_status_o=0 immediately; with FFT_IRQ_SYNC_EN defined, re-run basic capture expecting irq_o 4 cycles after the event.
